// File: rtl/mem_lsu_pkg.sv
// Shared types for the data-memory load/store unit: access-size codes,
// controller states, fault codes and the access-size normalisation helper.
package mem_lsu_pkg;

   // Access-size codes understood by mem_control
   localparam logic [1:0] MEM_ACCESS_BYTE     = 2'b00;
   localparam logic [1:0] MEM_ACCESS_HALFWORD = 2'b01;
   localparam logic [1:0] MEM_ACCESS_WORD     = 2'b10;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LD_ADDR = 3'd1,
      LD_DATA = 3'd2,
      ST_REQ  = 3'd3,
      ST_PEND = 3'd4,
      RESP    = 3'd5
   } lsu_state_e;

   typedef enum logic [1:0] {
      FAULT_NONE     = 2'b00,
      FAULT_MISALIGN = 2'b01,
      FAULT_RANGE    = 2'b10
   } lsu_fault_e;

   // The spare access code is handled exactly like a word access
   function automatic logic [1:0] acc_norm(input logic [1:0] acc);
      logic [1:0] res;
      case (acc)
         MEM_ACCESS_BYTE:     res = MEM_ACCESS_BYTE;
         MEM_ACCESS_HALFWORD: res = MEM_ACCESS_HALFWORD;
         MEM_ACCESS_WORD:     res = MEM_ACCESS_WORD;
         default:             res = MEM_ACCESS_WORD;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Bundle of the pipeline request/response handshake and the mem_control
// read/write port. The slave view belongs to the LSU; the master view is the
// surrounding system (execute stage on the request side, mem_control on the
// memory side).
interface mem_lsu_if;

   // pipeline request
   logic        req_valid_i;
   logic        req_ready_o;
   logic        req_we_i;
   logic [1:0]  req_acc_i;
   logic        req_sext_i;
   logic [31:0] req_addr_i;
   logic [31:0] req_wdata_i;

   // pipeline response
   logic        resp_valid_o;
   logic        resp_ready_i;
   logic [31:0] resp_rdata_o;
   logic [1:0]  resp_fault_o;

   // mem_control read port
   logic        mem_r_en_o;
   logic        mem_sext_o;
   logic [1:0]  mem_acc_r_o;
   logic [31:0] mem_addr_r_o;
   logic [31:0] mem_data_r_i;

   // mem_control write port
   logic        mem_wr_en_o;
   logic [1:0]  mem_acc_w_o;
   logic [31:0] mem_addr_w_o;
   logic [31:0] mem_data_w_o;
   logic        mem_wr_ready_i;

   modport slave (
      input  req_valid_i, req_we_i, req_acc_i, req_sext_i, req_addr_i, req_wdata_i,
      output req_ready_o,
      output resp_valid_o, resp_rdata_o, resp_fault_o,
      input  resp_ready_i,
      output mem_r_en_o, mem_sext_o, mem_acc_r_o, mem_addr_r_o,
      input  mem_data_r_i,
      output mem_wr_en_o, mem_acc_w_o, mem_addr_w_o, mem_data_w_o,
      input  mem_wr_ready_i
   );

   modport master (
      output req_valid_i, req_we_i, req_acc_i, req_sext_i, req_addr_i, req_wdata_i,
      input  req_ready_o,
      input  resp_valid_o, resp_rdata_o, resp_fault_o,
      output resp_ready_i,
      input  mem_r_en_o, mem_sext_o, mem_acc_r_o, mem_addr_r_o,
      output mem_data_r_i,
      input  mem_wr_en_o, mem_acc_w_o, mem_addr_w_o, mem_data_w_o,
      output mem_wr_ready_i
   );

endinterface

// File: rtl/mem_lsu_check.sv
// Combinational request screening: alignment first, then address window.
// The window limit is formed in 33 bits so BASE+SIZE cannot wrap to a small
// value and wrongly admit high addresses.
module mem_lsu_check
   import mem_lsu_pkg::*;
#(
   parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
   parameter logic [31:0] ADDR_SIZE = 32'h0000_0800
) (
   input  logic [1:0]  acc,
   input  logic [31:0] addr,
   output lsu_fault_e  fault
);

   logic        misalign_s;
   logic        in_range_s;
   logic [32:0] addr_ext_s;
   logic [32:0] lim_lo_s;
   logic [32:0] lim_hi_s;

   // Classify the request: misalignment takes precedence over range
   always_comb begin
      misalign_s = 1'b0;
      case (acc_norm(acc))
         MEM_ACCESS_BYTE:     misalign_s = 1'b0;
         MEM_ACCESS_HALFWORD: misalign_s = addr[0];
         MEM_ACCESS_WORD:     misalign_s = (addr[1:0] != 2'b00);
         default:             misalign_s = (addr[1:0] != 2'b00);
      endcase

      addr_ext_s = {1'b0, addr};
      lim_lo_s   = {1'b0, ADDR_BASE};
      lim_hi_s   = {1'b0, ADDR_BASE} + {1'b0, ADDR_SIZE};
      in_range_s = (addr_ext_s >= lim_lo_s) && (addr_ext_s < lim_hi_s);

      if (misalign_s) begin
         fault = FAULT_MISALIGN;
      end else if (!in_range_s) begin
         fault = FAULT_RANGE;
      end else begin
         fault = FAULT_NONE;
      end
   end

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit between the execute stage and mem_control. Accepts one
// request at a time, screens it, runs the two-cycle read or the
// request/merge write sequence, and holds the response until consumed.
// Every output is a flop; memory-port outputs carry the captured request
// only while a memory phase is active and are zero otherwise.
module mem_lsu
   import mem_lsu_pkg::*;
#(
   parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
   parameter logic [31:0] ADDR_SIZE = 32'h0000_0800
) (
   input  logic       clk_i,
   input  logic       rst_i,
   mem_lsu_if.slave   bus
);

   lsu_state_e  state_r;
   lsu_fault_e  fault_s;

   logic        req_ready_r;
   logic        resp_valid_r;
   logic [31:0] resp_rdata_r;
   logic [1:0]  resp_fault_r;

   logic        mem_r_en_r;
   logic        mem_sext_r;
   logic [1:0]  mem_acc_r_r;
   logic [31:0] mem_addr_r_r;

   logic        mem_wr_en_r;
   logic [1:0]  mem_acc_w_r;
   logic [31:0] mem_addr_w_r;
   logic [31:0] mem_data_w_r;

   logic        accept_s;

   mem_lsu_check #(
      .ADDR_BASE (ADDR_BASE),
      .ADDR_SIZE (ADDR_SIZE)
   ) u_check (
      .acc   (bus.req_acc_i),
      .addr  (bus.req_addr_i),
      .fault (fault_s)
   );

   assign accept_s = bus.req_valid_i & req_ready_r;

   // Request/response sequencer; all outputs are registered here
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_r      <= IDLE;
         req_ready_r  <= 1'b1;
         resp_valid_r <= 1'b0;
         resp_rdata_r <= 32'h0000_0000;
         resp_fault_r <= 2'b00;
         mem_r_en_r   <= 1'b0;
         mem_sext_r   <= 1'b0;
         mem_acc_r_r  <= 2'b00;
         mem_addr_r_r <= 32'h0000_0000;
         mem_wr_en_r  <= 1'b0;
         mem_acc_w_r  <= 2'b00;
         mem_addr_w_r <= 32'h0000_0000;
         mem_data_w_r <= 32'h0000_0000;
      end else begin
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  req_ready_r <= 1'b0;
                  if (fault_s != FAULT_NONE) begin
                     // faulting requests never touch the memory port
                     state_r      <= RESP;
                     resp_valid_r <= 1'b1;
                     resp_rdata_r <= 32'h0000_0000;
                     resp_fault_r <= fault_s;
                  end else if (bus.req_we_i) begin
                     state_r      <= ST_REQ;
                     mem_wr_en_r  <= 1'b1;
                     mem_acc_w_r  <= acc_norm(bus.req_acc_i);
                     mem_addr_w_r <= bus.req_addr_i;
                     mem_data_w_r <= bus.req_wdata_i;
                  end else begin
                     state_r      <= LD_ADDR;
                     mem_r_en_r   <= 1'b1;
                     mem_sext_r   <= bus.req_sext_i;
                     mem_acc_r_r  <= acc_norm(bus.req_acc_i);
                     mem_addr_r_r <= bus.req_addr_i;
                  end
               end else begin
                  state_r <= IDLE;
               end
            end

            LD_ADDR: begin
               // read port held; mem_control registers the read this cycle
               state_r <= LD_DATA;
            end

            LD_DATA: begin
               state_r      <= RESP;
               resp_valid_r <= 1'b1;
               resp_rdata_r <= bus.mem_data_r_i;
               resp_fault_r <= FAULT_NONE;
               mem_r_en_r   <= 1'b0;
               mem_sext_r   <= 1'b0;
               mem_acc_r_r  <= 2'b00;
               mem_addr_r_r <= 32'h0000_0000;
            end

            ST_REQ: begin
               if (bus.mem_wr_ready_i) begin
                  // drop the enable but keep addr/acc/data for the merge cycle
                  state_r     <= ST_PEND;
                  mem_wr_en_r <= 1'b0;
               end else begin
                  state_r <= ST_REQ;
               end
            end

            ST_PEND: begin
               state_r      <= RESP;
               resp_valid_r <= 1'b1;
               resp_rdata_r <= 32'h0000_0000;
               resp_fault_r <= FAULT_NONE;
               mem_acc_w_r  <= 2'b00;
               mem_addr_w_r <= 32'h0000_0000;
               mem_data_w_r <= 32'h0000_0000;
            end

            RESP: begin
               if (bus.resp_ready_i) begin
                  state_r      <= IDLE;
                  req_ready_r  <= 1'b1;
                  resp_valid_r <= 1'b0;
                  resp_rdata_r <= 32'h0000_0000;
                  resp_fault_r <= 2'b00;
               end else begin
                  state_r <= RESP;
               end
            end

            default: begin
               // unreachable encoding: recover to a clean idle
               state_r      <= IDLE;
               req_ready_r  <= 1'b1;
               resp_valid_r <= 1'b0;
               resp_rdata_r <= 32'h0000_0000;
               resp_fault_r <= 2'b00;
               mem_r_en_r   <= 1'b0;
               mem_sext_r   <= 1'b0;
               mem_acc_r_r  <= 2'b00;
               mem_addr_r_r <= 32'h0000_0000;
               mem_wr_en_r  <= 1'b0;
               mem_acc_w_r  <= 2'b00;
               mem_addr_w_r <= 32'h0000_0000;
               mem_data_w_r <= 32'h0000_0000;
            end
         endcase
      end
   end

   assign bus.req_ready_o   = req_ready_r;
   assign bus.resp_valid_o  = resp_valid_r;
   assign bus.resp_rdata_o  = resp_rdata_r;
   assign bus.resp_fault_o  = resp_fault_r;
   assign bus.mem_r_en_o    = mem_r_en_r;
   assign bus.mem_sext_o    = mem_sext_r;
   assign bus.mem_acc_r_o   = mem_acc_r_r;
   assign bus.mem_addr_r_o  = mem_addr_r_r;
   assign bus.mem_wr_en_o   = mem_wr_en_r;
   assign bus.mem_acc_w_o   = mem_acc_w_r;
   assign bus.mem_addr_w_o  = mem_addr_w_r;
   assign bus.mem_data_w_o  = mem_data_w_r;

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: a behavioural mem_control stand-in, directed requests
// with hand-computed results queued as expectations, and a monitor that pops
// and compares on every consumed response.
module tb_mem_lsu;

   logic clk;
   logic rst;

   mem_lsu_if bus ();

   mem_lsu #(
      .ADDR_BASE (32'h0000_0000),
      .ADDR_SIZE (32'h0000_0800)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [31:0] rdata;
      logic [1:0]  fault;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;

   // ---------------- mem_control stand-in ----------------
   logic [31:0] mem_w [0:511];
   logic [31:0] rd_data_r;
   logic        pend_r;
   logic        mem_init_r = 1'b0;
   int          wr_count = 0;
   int          en_cnt = 0;

   function automatic logic [31:0] rd_ext(input logic [31:0] w, input logic [1:0] off,
                                          input logic [1:0] acc, input logic sext);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = w[{off, 3'b000} +: 8];
      h = off[1] ? w[31:16] : w[15:0];
      case (acc)
         2'b00:   r = sext ? {{24{b[7]}}, b} : {24'h000000, b};
         2'b01:   r = sext ? {{16{h[15]}}, h} : {16'h0000, h};
         default: r = w;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] wr_merge(input logic [31:0] w, input logic [1:0] off,
                                            input logic [1:0] acc, input logic [31:0] d);
      logic [31:0] r;
      r = w;
      case (acc)
         2'b00:   r[{off, 3'b000} +: 8] = d[7:0];
         2'b01:   if (off[1]) r[31:16] = d[15:0]; else r[15:0] = d[15:0];
         default: r = d;
      endcase
      return r;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data_r <= 32'h0;
         pend_r    <= 1'b0;
         if (!mem_init_r) begin
            for (int i = 0; i < 512; i++) mem_w[i] <= 32'h0;
            mem_w[9'h040] <= 32'h1122_3344;
            mem_w[9'h041] <= 32'h80FF_1234;
            mem_w[9'h1FF] <= 32'hCAFE_F00D;
            mem_init_r    <= 1'b1;
         end
      end else begin
         if (bus.mem_r_en_o)
            rd_data_r <= rd_ext(mem_w[bus.mem_addr_r_o[10:2]], bus.mem_addr_r_o[1:0],
                                bus.mem_acc_r_o, bus.mem_sext_o);
         pend_r <= bus.mem_wr_en_o & bus.mem_wr_ready_i;
         if (pend_r) begin
            mem_w[bus.mem_addr_w_o[10:2]] <= wr_merge(mem_w[bus.mem_addr_w_o[10:2]],
                                                     bus.mem_addr_w_o[1:0], bus.mem_acc_w_o,
                                                     bus.mem_data_w_o);
            wr_count <= wr_count + 1;
         end
      end
   end

   assign bus.mem_data_r_i = rd_data_r;

   always @(negedge clk) begin
      if (bus.mem_r_en_o | bus.mem_wr_en_o) en_cnt <= en_cnt + 1;
   end

   // ---------------- checking ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && bus.resp_valid_o && bus.resp_ready_i) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL resp_unexpected actual=%h required=none", bus.resp_rdata_o);
         end else begin
            mon_e = exp_q.pop_front();
            chk("resp_rdata", bus.resp_rdata_o, mon_e.rdata);
            chk("resp_fault", {30'd0, bus.resp_fault_o}, {30'd0, mon_e.fault});
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic issue(input logic we, input logic [1:0] acc, input logic sext,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic [1:0] exp_f);
      int n;
      exp_t e;
      e = {exp_rd, exp_f};
      exp_q.push_back(e);
      @(negedge clk);
      bus.req_valid_i = 1'b1;
      bus.req_we_i    = we;
      bus.req_acc_i   = acc;
      bus.req_sext_i  = sext;
      bus.req_addr_i  = addr;
      bus.req_wdata_i = wd;
      n = 0;
      while (!bus.req_ready_o && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         checks++;
         failures++;
         $display("FAIL accept_timeout actual=not_ready required=ready");
      end
      @(posedge clk);
      @(negedge clk);
      bus.req_valid_i = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || !bus.req_ready_o) && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 100) begin
         failures++;
         $display("FAIL idle_timeout actual=busy required=idle");
      end
   endtask

   int c0;

   initial begin
      rst = 1'b1;
      bus.req_valid_i    = 1'b0;
      bus.req_we_i       = 1'b0;
      bus.req_acc_i      = 2'b00;
      bus.req_sext_i     = 1'b0;
      bus.req_addr_i     = 32'h0;
      bus.req_wdata_i    = 32'h0;
      bus.resp_ready_i   = 1'b1;
      bus.mem_wr_ready_i = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_req_ready", {31'd0, bus.req_ready_o}, 32'd1);
      chk("rst_resp_valid", {31'd0, bus.resp_valid_o}, 32'd0);
      chk("rst_r_en", {31'd0, bus.mem_r_en_o}, 32'd0);
      chk("rst_wr_en", {31'd0, bus.mem_wr_en_o}, 32'd0);
      chk("rst_addr_w", bus.mem_addr_w_o, 32'h0);
      chk("rst_rdata", bus.resp_rdata_o, 32'h0);
      rst = 1'b0;

      // store byte right after reset with write-ready held low
      issue(1'b1, 2'b00, 1'b0, 32'h0000_0101, 32'h0000_00AB, 32'h0, 2'b00);
      repeat (4) begin
         chk("st_req_wr_en", {31'd0, bus.mem_wr_en_o}, 32'd1);
         chk("st_req_addr", bus.mem_addr_w_o, 32'h0000_0101);
         chk("st_req_no_write", wr_count, 32'd0);
         @(negedge clk);
      end
      bus.mem_wr_ready_i = 1'b1;
      @(negedge clk);
      chk("st_pend_wr_en", {31'd0, bus.mem_wr_en_o}, 32'd0);
      chk("st_pend_addr", bus.mem_addr_w_o, 32'h0000_0101);
      chk("st_pend_data", bus.mem_data_w_o, 32'h0000_00AB);
      chk("st_pend_acc", {30'd0, bus.mem_acc_w_o}, 32'd0);
      bus.mem_wr_ready_i = 1'b0;
      @(negedge clk);
      chk("st_resp_valid", {31'd0, bus.resp_valid_o}, 32'd1);
      chk("st_write_once", wr_count, 32'd1);
      chk("st_mem_word", mem_w[9'h040], 32'h1122_AB44);
      wait_idle();

      // word load sees the merged byte; address stable over both load cycles
      issue(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 32'h1122_AB44, 2'b00);
      chk("ld_addr_r_en", {31'd0, bus.mem_r_en_o}, 32'd1);
      chk("ld_addr_addr", bus.mem_addr_r_o, 32'h0000_0100);
      @(negedge clk);
      chk("ld_data_r_en", {31'd0, bus.mem_r_en_o}, 32'd1);
      chk("ld_data_addr", bus.mem_addr_r_o, 32'h0000_0100);
      chk("ld_data_no_resp", {31'd0, bus.resp_valid_o}, 32'd0);
      @(negedge clk);
      chk("ld_resp_latency", {31'd0, bus.resp_valid_o}, 32'd1);
      wait_idle();

      // half loads with and without sign extension
      issue(1'b0, 2'b01, 1'b1, 32'h0000_0106, 32'h0, 32'hFFFF_80FF, 2'b00);
      wait_idle();
      issue(1'b0, 2'b01, 1'b0, 32'h0000_0106, 32'h0, 32'h0000_80FF, 2'b00);
      wait_idle();

      // misaligned requests: one-cycle fault, no memory enables
      c0 = en_cnt;
      issue(1'b0, 2'b01, 1'b0, 32'h0000_0103, 32'h0, 32'h0, 2'b01);
      chk("fault_latency", {31'd0, bus.resp_valid_o}, 32'd1);
      wait_idle();
      issue(1'b1, 2'b10, 1'b0, 32'h0000_0102, 32'h5555_AAAA, 32'h0, 2'b01);
      wait_idle();
      // misalignment outranks range
      issue(1'b0, 2'b01, 1'b0, 32'h0000_0801, 32'h0, 32'h0, 2'b01);
      wait_idle();
      // range boundaries, including the top of the address space
      issue(1'b0, 2'b10, 1'b0, 32'h0000_0800, 32'h0, 32'h0, 2'b10);
      wait_idle();
      issue(1'b1, 2'b10, 1'b0, 32'hFFFF_FFFC, 32'h1234_5678, 32'h0, 2'b10);
      wait_idle();
      chk("fault_no_enables", en_cnt, c0);
      chk("fault_no_write", wr_count, 32'd1);
      issue(1'b0, 2'b10, 1'b0, 32'h0000_07FC, 32'h0, 32'hCAFE_F00D, 2'b00);
      wait_idle();
      issue(1'b0, 2'b00, 1'b1, 32'h0000_07FF, 32'h0, 32'hFFFF_FFCA, 2'b00);
      wait_idle();
      // unused access code behaves as a word
      issue(1'b0, 2'b11, 1'b0, 32'h0000_0104, 32'h0, 32'h80FF_1234, 2'b00);
      wait_idle();

      // response back-pressure
      @(posedge clk);
      #1 bus.resp_ready_i = 1'b0;
      issue(1'b0, 2'b10, 1'b0, 32'h0000_0104, 32'h0, 32'h80FF_1234, 2'b00);
      @(negedge clk);
      @(negedge clk);
      repeat (5) begin
         chk("stall_valid", {31'd0, bus.resp_valid_o}, 32'd1);
         chk("stall_rdata", bus.resp_rdata_o, 32'h80FF_1234);
         chk("stall_req_ready", {31'd0, bus.req_ready_o}, 32'd0);
         @(negedge clk);
      end
      @(posedge clk);
      #1 bus.resp_ready_i = 1'b1;
      wait_idle();

      // asynchronous reset in the middle of LD_DATA
      issue(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 32'h1122_AB44, 2'b00);
      @(posedge clk);
      #2;
      chk("pre_rst_r_en", {31'd0, bus.mem_r_en_o}, 32'd1);
      rst = 1'b1;
      #1;
      chk("mid_rst_req_ready", {31'd0, bus.req_ready_o}, 32'd1);
      chk("mid_rst_resp_valid", {31'd0, bus.resp_valid_o}, 32'd0);
      chk("mid_rst_r_en", {31'd0, bus.mem_r_en_o}, 32'd0);
      chk("mid_rst_addr_r", bus.mem_addr_r_o, 32'h0);
      chk("mid_rst_wr_en", {31'd0, bus.mem_wr_en_o}, 32'd0);
      chk("mid_rst_rdata", bus.resp_rdata_o, 32'h0);
      chk("mid_rst_fault", {30'd0, bus.resp_fault_o}, 32'd0);
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;

      // recovery after reset
      issue(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 32'h1122_AB44, 2'b00);
      wait_idle();
      chk("final_write_count", wr_count, 32'd1);
      chk("final_queue_empty", exp_q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
